mips_id_ex_core: RTL and testbench
==================================

Name: mips_id_ex_core

Overview:
- Decode stage, register file, ID/EX register, execute stage, EX/MEM register and hazard/forwarding control of a 5-stage 32-bit MIPS pipeline.
- Instruction fetch and data memory sit outside this block:
  - Fetch supplies InstrD and PCPlus4D, and consumes StallF, StallD, PCSrcD and PCBranchD.
  - The memory stage consumes the *M outputs and returns the writeback triple (RegWriteW, WriteRegW, ResultW).
- Branches resolve in ID.

Parameters:
- none. Data width is fixed at 32 bits and the register file at 32 entries.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- InstrD  in  32  instruction held in the IF/ID register
- PCPlus4D  in  32  PC+4 of InstrD
- RegWriteW  in  1  writeback enable
- WriteRegW  in  5  writeback destination register
- ResultW  in  32  writeback data
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- PCSrcD  out  1  take branch
- PCBranchD  out  32  branch target
- RegWriteM  out  1  EX/MEM register write enable
- MemtoRegM  out  1  EX/MEM load flag
- MemWriteM  out  1  EX/MEM store flag
- WriteRegM  out  5  EX/MEM destination register
- ALUOutM  out  32  EX/MEM ALU result
- WriteDataM  out  32  EX/MEM store data (forwarded rt value)

Behaviour:
- Reset (async, rst=1):
  - Register file entries are all 0.
  - ID/EX and EX/MEM registers are cleared, i.e. a bubble.
  - All outputs read 0.
- Decode. Supported instructions, with ALUControl code:
  - add 010, sub 110, and 000, or 001, slt 111, sll 100, srl 101 (all R-type)
  - addi 010, lw 010, sw 010
  - beq, bne
  - Any other opcode or funct decodes as a NOP: all control bits 0.
- Destination register: RegDst=1 (R-type) selects rd; otherwise rt.
- Immediate: SignImm is the sign-extended instr[15:0].
- Register file:
  - Two combinational read ports addressed by rs and rt; one write port, written at posedge clk when RegWriteW=1.
  - A read of the register being written in the same cycle returns ResultW (write-through).
  - Register $0 always reads 0; writes to $0 are ignored.
- Branch:
  - Compare operands are the register file outputs, each replaced by ALUOutM when its ForwardAD/ForwardBD select is 1.
  - eq = (A == B). PCSrcD = Branch & (eq XOR isBne).
  - PCBranchD = PCPlus4D + (SignImm << 2), valid every cycle.
- ID/EX register:
  - Loads every posedge.
  - When FlushE=1, all control bits and rs/rt/rd are cleared instead.
- EX stage:
  - SrcA mux on ForwardAE: 00 = RD1E, 01 = ResultW, 10 = ALUOutM.
  - SrcB_pre mux on ForwardBE uses the same encoding.
  - SrcB = SignImmE when ALUSrc=1, else SrcB_pre.
  - ALU ops: add and sub are modulo 2^32; slt is a signed compare giving 1 or 0.
  - sll/srl shift SrcB by the shamt field; SrcA is ignored.
  - Zero flag is not used.
- EX/MEM register: loads every posedge with ALU result, SrcB_pre (as WriteDataM), destination register and control bits.
- Latency: an instruction on InstrD at cycle n appears on the *M outputs after the 2nd following rising edge.
- Hazard unit (combinational):
  - ForwardAE = 10 when rsE≠0 & rsE==WriteRegM & RegWriteM.
  - Otherwise ForwardAE = 01 when rsE≠0 & rsE==WriteRegW & RegWriteW.
  - Otherwise ForwardAE = 00. ForwardBE is the same with rtE.
  - M-stage forwarding takes priority over W-stage on a simultaneous match.
  - ForwardAD = rsD≠0 & rsD==WriteRegM & RegWriteM. ForwardBD is the same with rtD.
  - lwstall = MemtoRegE & (rsD==rtE | rtD==rtE).
  - branchstall = BranchD & [ (RegWriteE & (WriteRegE==rsD | WriteRegE==rtD)) | (MemtoRegM & (WriteRegM==rsD | WriteRegM==rtD)) ].
  - StallF = StallD = FlushE = lwstall | branchstall.
- During a stall:
  - The block relies on fetch holding InstrD.
  - Exactly one bubble enters EX per stall cycle.
  - PCSrcD is still computed and is ignored by fetch while StallD=1.
- Reset asserted mid-operation discards every in-flight instruction.

Decomposition:
- Shared package mips_pkg:
  - opcode and funct constants
  - ALUControl codes
  - forward-select encodings (00/01/10)
- One sub-module, mips_hazard_unit, containing the forwarding and stall logic above.
- ALU and register file stay inline.

Test Plan:
- Reset: assert rst while feeding arbitrary instructions -> all outputs 0; no register writes.
- EX forwarding:
  - Stimulus: addi $1,$0,5 (0x20010005) then add $2,$1,$1 (0x00211020) on consecutive cycles, writeback driven from the *M outputs one cycle later.
  - Response: ForwardAE = ForwardBE = 10; add yields ALUOutM=10, WriteRegM=2, RegWriteM=1.
- Load-use stall:
  - Stimulus: lw $3,0($0) (0x8C030000) then add $4,$3,$3 (0x00632020).
  - Response: StallF = StallD = 1 for exactly one cycle; the next EX/MEM cycle shows RegWriteM=0 (bubble); the add then uses ForwardAE=01 with ResultW.
- Branch:
  - Stimulus: $1=5, PCPlus4D=0x10, beq $1,$1,3 (0x10210003).
  - Response: PCSrcD=1, PCBranchD=0x1C. The bne version (0x14210003) gives PCSrcD=0.
  - With addi $1 immediately before: branchstall for 1 cycle, then ForwardAD=1.
- Shift and compare, with $1=5:
  - sll $5,$1,2 (0x00012880) -> ALUOutM=20.
  - slt $6,$0,$1 -> 1.
  - sub $7,$0,$1 -> 0xFFFFFFFB.
- Store and $0:
  - sw $1,4($0) (0xAC010004) -> MemWriteM=1, ALUOutM=4, WriteDataM=5, RegWriteM=0.
  - Writeback to $0 with ResultW=0xFF -> $0 still reads 0, and no forwarding selected for rs=$0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, functs, ALU codes,
// forwarding selects, pipeline control bundles and the main decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      branch;
    logic      is_bne;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // Branch bits are consumed in ID, so EX only carries the rest.
  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_ctrl;
  } ex_ctrl_t;

  typedef struct packed {
    ex_ctrl_t    ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] wdata;
  } exmem_t;

  // Unsupported opcodes/functs fall out as an all-zero control word.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (instr[5:0])
          F_ADD:   c.alu_ctrl = ALU_ADD;
          F_SUB:   c.alu_ctrl = ALU_SUB;
          F_AND:   c.alu_ctrl = ALU_AND;
          F_OR:    c.alu_ctrl = ALU_OR;
          F_SLT:   c.alu_ctrl = ALU_SLT;
          F_SLL:   c.alu_ctrl = ALU_SLL;
          F_SRL:   c.alu_ctrl = ALU_SRL;
          default: c = '0;
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      OP_BNE: begin
        c.branch   = 1'b1;
        c.is_bne   = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_id_ex_core_hazard.sv
// Forwarding selects for the ID comparator and EX operands, plus load-use and
// branch stall detection.
module mips_hazard_unit
  import mips_pkg::*;
(
  input  logic [4:0] rs_d_i,
  input  logic [4:0] rt_d_i,
  input  logic       branch_d_i,
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rt_e_i,
  input  logic [4:0] wreg_e_i,
  input  logic       reg_write_e_i,
  input  logic       mem_to_reg_e_i,
  input  logic [4:0] wreg_m_i,
  input  logic       reg_write_m_i,
  input  logic       mem_to_reg_m_i,
  input  logic [4:0] wreg_w_i,
  input  logic       reg_write_w_i,
  output fwd_sel_e   fwd_ae_o,
  output fwd_sel_e   fwd_be_o,
  output logic       fwd_ad_o,
  output logic       fwd_bd_o,
  output logic       stall_f_o,
  output logic       stall_d_o,
  output logic       flush_e_o
);

  logic lwstall, branchstall, stall;

  // M-stage match wins over W since it holds the younger value.
  always_comb begin
    fwd_ae_o = FWD_RF;
    if (rs_e_i != 5'd0 && rs_e_i == wreg_m_i && reg_write_m_i)      fwd_ae_o = FWD_MEM;
    else if (rs_e_i != 5'd0 && rs_e_i == wreg_w_i && reg_write_w_i) fwd_ae_o = FWD_WB;
    fwd_be_o = FWD_RF;
    if (rt_e_i != 5'd0 && rt_e_i == wreg_m_i && reg_write_m_i)      fwd_be_o = FWD_MEM;
    else if (rt_e_i != 5'd0 && rt_e_i == wreg_w_i && reg_write_w_i) fwd_be_o = FWD_WB;
  end

  assign fwd_ad_o = (rs_d_i != 5'd0) && (rs_d_i == wreg_m_i) && reg_write_m_i;
  assign fwd_bd_o = (rt_d_i != 5'd0) && (rt_d_i == wreg_m_i) && reg_write_m_i;

  assign lwstall     = mem_to_reg_e_i && ((rs_d_i == rt_e_i) || (rt_d_i == rt_e_i));
  assign branchstall = branch_d_i &&
                       ((reg_write_e_i && (wreg_e_i == rs_d_i || wreg_e_i == rt_d_i)) ||
                        (mem_to_reg_m_i && (wreg_m_i == rs_d_i || wreg_m_i == rt_d_i)));
  assign stall       = lwstall || branchstall;

  assign stall_f_o = stall;
  assign stall_d_o = stall;
  assign flush_e_o = stall;

endmodule

// File: rtl/mips_id_ex_core.sv
// ID and EX stages of a 5-stage MIPS pipeline: decode, register file, branch
// resolution, ID/EX and EX/MEM registers, ALU and hazard control.
module mips_id_ex_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  output logic        StallF,
  output logic        StallD,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM
);

  ctrl_t       ctrlD;
  logic [4:0]  rsD, rtD, rdD;
  logic [31:0] immD, rd1D, rd2D, cmpAD, cmpBD;
  logic        ForwardAD, ForwardBD, FlushE;
  fwd_sel_e    ForwardAE, ForwardBE;

  logic [31:0] rf_q [32];
  idex_t       idex_d, idex_q;
  exmem_t      exmem_d, exmem_q;

  logic [4:0]  wregE;
  logic [31:0] srcAE, srcBpreE, srcBE, aluE;

  assign ctrlD = decode(InstrD);
  assign rsD   = InstrD[25:21];
  assign rtD   = InstrD[20:16];
  assign rdD   = InstrD[15:11];
  assign immD  = {{16{InstrD[15]}}, InstrD[15:0]};

  // Write-through lets an instruction in ID see the value retiring this cycle.
  always_comb begin
    rd1D = rf_q[rsD];
    rd2D = rf_q[rtD];
    if (RegWriteW && WriteRegW == rsD) rd1D = ResultW;
    if (RegWriteW && WriteRegW == rtD) rd2D = ResultW;
    if (rsD == 5'd0) rd1D = '0;
    if (rtD == 5'd0) rd2D = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWriteW && WriteRegW != 5'd0) begin
      rf_q[WriteRegW] <= ResultW;
    end
  end

  // Branch outputs are combinational; hold them at 0 while reset is asserted.
  assign cmpAD     = ForwardAD ? ALUOutM : rd1D;
  assign cmpBD     = ForwardBD ? ALUOutM : rd2D;
  assign PCSrcD    = !rst && ctrlD.branch && ((cmpAD == cmpBD) ^ ctrlD.is_bne);
  assign PCBranchD = rst ? '0 : PCPlus4D + {immD[29:0], 2'b00};

  always_comb begin
    idex_d.ctrl.reg_write  = ctrlD.reg_write;
    idex_d.ctrl.mem_to_reg = ctrlD.mem_to_reg;
    idex_d.ctrl.mem_write  = ctrlD.mem_write;
    idex_d.ctrl.alu_src    = ctrlD.alu_src;
    idex_d.ctrl.reg_dst    = ctrlD.reg_dst;
    idex_d.ctrl.alu_ctrl   = ctrlD.alu_ctrl;
    idex_d.rd1             = rd1D;
    idex_d.rd2             = rd2D;
    idex_d.imm             = immD;
    idex_d.rs              = rsD;
    idex_d.rt              = rtD;
    idex_d.rd              = rdD;
    idex_d.shamt           = InstrD[10:6];
    if (FlushE) begin
      idex_d.ctrl = '0;
      idex_d.rs   = '0;
      idex_d.rt   = '0;
      idex_d.rd   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign wregE = idex_q.ctrl.reg_dst ? idex_q.rd : idex_q.rt;

  always_comb begin
    case (ForwardAE)
      FWD_MEM: srcAE = ALUOutM;
      FWD_WB:  srcAE = ResultW;
      default: srcAE = idex_q.rd1;
    endcase
    case (ForwardBE)
      FWD_MEM: srcBpreE = ALUOutM;
      FWD_WB:  srcBpreE = ResultW;
      default: srcBpreE = idex_q.rd2;
    endcase
  end

  assign srcBE = idex_q.ctrl.alu_src ? idex_q.imm : srcBpreE;

  always_comb begin
    case (idex_q.ctrl.alu_ctrl)
      ALU_AND: aluE = srcAE & srcBE;
      ALU_OR:  aluE = srcAE | srcBE;
      ALU_ADD: aluE = srcAE + srcBE;
      ALU_SUB: aluE = srcAE - srcBE;
      ALU_SLT: aluE = {31'b0, $signed(srcAE) < $signed(srcBE)};
      ALU_SLL: aluE = srcBE << idex_q.shamt;
      ALU_SRL: aluE = srcBE >> idex_q.shamt;
      default: aluE = '0;
    endcase
  end

  always_comb begin
    exmem_d.reg_write  = idex_q.ctrl.reg_write;
    exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
    exmem_d.mem_write  = idex_q.ctrl.mem_write;
    exmem_d.wreg       = wregE;
    exmem_d.alu        = aluE;
    exmem_d.wdata      = srcBpreE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exmem_q <= '0;
    else     exmem_q <= exmem_d;
  end

  assign RegWriteM  = exmem_q.reg_write;
  assign MemtoRegM  = exmem_q.mem_to_reg;
  assign MemWriteM  = exmem_q.mem_write;
  assign WriteRegM  = exmem_q.wreg;
  assign ALUOutM    = exmem_q.alu;
  assign WriteDataM = exmem_q.wdata;

  mips_hazard_unit u_hazard (
    .rs_d_i         (rsD),
    .rt_d_i         (rtD),
    .branch_d_i     (ctrlD.branch),
    .rs_e_i         (idex_q.rs),
    .rt_e_i         (idex_q.rt),
    .wreg_e_i       (wregE),
    .reg_write_e_i  (idex_q.ctrl.reg_write),
    .mem_to_reg_e_i (idex_q.ctrl.mem_to_reg),
    .wreg_m_i       (WriteRegM),
    .reg_write_m_i  (RegWriteM),
    .mem_to_reg_m_i (MemtoRegM),
    .wreg_w_i       (WriteRegW),
    .reg_write_w_i  (RegWriteW),
    .fwd_ae_o       (ForwardAE),
    .fwd_be_o       (ForwardBE),
    .fwd_ad_o       (ForwardAD),
    .fwd_bd_o       (ForwardBD),
    .stall_f_o      (StallF),
    .stall_d_o      (StallD),
    .flush_e_o      (FlushE)
  );

endmodule

// File: tb/tb_mips_id_ex_core.sv
// Bench for mips_id_ex_core: an ISA-level model pushes expected EX/MEM results to a
// scoreboard at issue; a monitor pops them as the DUT commits. Memory/writeback is modeled here.
module tb_mips_id_ex_core;

  localparam logic [31:0] NOP_I = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrD = NOP_I;
  logic [31:0] PCPlus4D = '0;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, WriteDataM;

  mips_id_ex_core dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .StallF(StallF), .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, m2r, mw;
    logic [4:0]  wr;
    logic [31:0] alu, wd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mreg [32];
  logic [31:0] mmem [32];
  logic [31:0] dmem [32];
  int          checks = 0;
  int          errors = 0;

  int          last_stalls;
  logic        b_pcsrc, b_fad, b_fbd;
  logic [31:0] b_pcbr;
  logic [1:0]  fae, fbe;

  // Memory stage + MEM/WB register of the surrounding pipeline.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      WriteRegW <= '0;
      ResultW   <= '0;
      for (int i = 0; i < 32; i++) dmem[i] <= 32'h11 * (i + 1);
    end else begin
      RegWriteW <= RegWriteM;
      WriteRegW <= WriteRegM;
      ResultW   <= MemtoRegM ? dmem[ALUOutM[6:2]] : ALUOutM;
      if (MemWriteM) dmem[ALUOutM[6:2]] <= WriteDataM;
    end
  end

  exp_t e;
  always @(negedge clk) begin
    if (!rst && (RegWriteM || MemWriteM)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rw=%0b mw=%0b wr=%0d alu=%h, required no commit",
                 RegWriteM, MemWriteM, WriteRegM, ALUOutM);
      end else begin
        e = sb.pop_front();
        if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUOutM, WriteDataM} !==
            {e.rw, e.m2r, e.mw, e.wr, e.alu, e.wd}) begin
          errors++;
          $display("FAIL sb_commit: got rw=%0b m2r=%0b mw=%0b wr=%0d alu=%h wd=%h, required rw=%0b m2r=%0b mw=%0b wr=%0d alu=%h wd=%h",
                   RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUOutM, WriteDataM,
                   e.rw, e.m2r, e.mw, e.wr, e.alu, e.wd);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mmem[i] = 32'h11 * (i + 1);
    end
    sb.delete();
  endtask

  // Architectural (in-order) execution of one instruction.
  task automatic model_push(input logic [31:0] ins);
    exp_t        x;
    logic [31:0] a, b, imm, ld;
    logic [4:0]  rs, rt, rd, sh;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    imm = {{16{ins[15]}}, ins[15:0]};
    a = mreg[rs]; b = mreg[rt];
    x = '{rw: 1'b0, m2r: 1'b0, mw: 1'b0, wr: rt, alu: 32'h0, wd: b};
    ld = '0;
    case (ins[31:26])
      6'b000000: begin
        x.rw = 1'b1; x.wr = rd;
        case (ins[5:0])
          6'b100000: x.alu = a + b;
          6'b100010: x.alu = a - b;
          6'b100100: x.alu = a & b;
          6'b100101: x.alu = a | b;
          6'b101010: x.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'b000000: x.alu = b << sh;
          6'b000010: x.alu = b >> sh;
          default:   x.rw = 1'b0;
        endcase
      end
      6'b001000: begin x.rw = 1'b1; x.alu = a + imm; end
      6'b100011: begin x.rw = 1'b1; x.m2r = 1'b1; x.alu = a + imm; ld = mmem[x.alu[6:2]]; end
      6'b101011: begin x.mw = 1'b1; x.alu = a + imm; mmem[x.alu[6:2]] = b; end
      default: ;
    endcase
    if (x.rw || x.mw) sb.push_back(x);
    if (x.rw && x.wr != 5'd0) mreg[x.wr] = x.m2r ? ld : x.alu;
  endtask

  // Holds ins on InstrD until accepted; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc4);
    InstrD = ins; PCPlus4D = pc4; last_stalls = 0;
    #1;
    while (StallD === 1'b1 && last_stalls < 8) begin
      checks++;
      if (StallF !== StallD) begin
        errors++;
        $display("FAIL stallf_eq_stalld: got StallF=%0b, required %0b", StallF, StallD);
      end
      last_stalls++;
      @(posedge clk); #1;
    end
    checks++;
    if (StallD !== 1'b0) begin
      errors++;
      $display("FAIL issue_timeout: got StallD=%0b after %0d cycles, required 0", StallD, last_stalls);
    end
    b_pcsrc = PCSrcD; b_pcbr = PCBranchD; b_fad = dut.ForwardAD; b_fbd = dut.ForwardBD;
    model_push(ins);
    @(posedge clk); #1;
    fae = dut.ForwardAE; fbe = dut.ForwardBE;
    InstrD = NOP_I;
  endtask

  task automatic test_reset();
    logic [31:0] tbl [3];
    tbl[0] = 32'h1000_0003; tbl[1] = 32'h2001_0005; tbl[2] = 32'h8C03_0000;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InstrD = tbl[i]; PCPlus4D = 32'h100 + 32'(i * 4);
      @(negedge clk);
      checks++;
      if ({StallF, StallD, PCSrcD, PCBranchD, RegWriteM, MemtoRegM, MemWriteM,
           WriteRegM, ALUOutM, WriteDataM} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got pcsrc=%0b pcbr=%h rw=%0b alu=%h stall=%0b, required all 0",
                 PCSrcD, PCBranchD, RegWriteM, ALUOutM, StallD);
      end
    end
    @(posedge clk); #1;
    InstrD = NOP_I; rst = 1'b0;
    model_reset();
    // $1 must still read 0 after reset despite addi having been presented.
    issue(32'h0021_9820, 32'h0);
  endtask

  task automatic test_ex_forward();
    issue(32'h2001_0005, 32'h0);
    issue(32'h0021_1020, 32'h0);
    checks++;
    if (fae !== 2'b10 || fbe !== 2'b10) begin
      errors++;
      $display("FAIL ex_forward_sel: got AE=%b BE=%b, required AE=10 BE=10", fae, fbe);
    end
  endtask

  task automatic test_load_use();
    issue(32'h8C03_0000, 32'h0);
    issue(32'h0063_2020, 32'h0);
    checks++;
    if (last_stalls !== 1) begin
      errors++;
      $display("FAIL load_use_stalls: got %0d stall cycles, required 1", last_stalls);
    end
    checks++;
    if (RegWriteM !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: got RegWriteM=%0b, required 0", RegWriteM);
    end
    checks++;
    if (fae !== 2'b01 || fbe !== 2'b01) begin
      errors++;
      $display("FAIL load_use_fwd: got AE=%b BE=%b, required AE=01 BE=01", fae, fbe);
    end
  endtask

  task automatic test_branch();
    issue(32'h2001_0005, 32'h0);
    issue(NOP_I, 32'h0);
    issue(NOP_I, 32'h0);
    issue(32'h1021_0003, 32'h10);
    checks++;
    if (b_pcsrc !== 1'b1 || b_pcbr !== 32'h1C || last_stalls !== 0) begin
      errors++;
      $display("FAIL beq_taken: got pcsrc=%0b pcbr=%h stalls=%0d, required 1 0000001c 0",
               b_pcsrc, b_pcbr, last_stalls);
    end
    issue(32'h1421_0003, 32'h10);
    checks++;
    if (b_pcsrc !== 1'b0 || b_pcbr !== 32'h1C) begin
      errors++;
      $display("FAIL bne_not_taken: got pcsrc=%0b pcbr=%h, required 0 0000001c", b_pcsrc, b_pcbr);
    end
    issue(32'h2001_0007, 32'h0);
    issue(32'h1021_0003, 32'h10);
    checks++;
    if (last_stalls !== 1 || b_fad !== 1'b1 || b_fbd !== 1'b1 || b_pcsrc !== 1'b1) begin
      errors++;
      $display("FAIL branch_stall_fwd: got stalls=%0d fad=%0b fbd=%0b pcsrc=%0b, required 1 1 1 1",
               last_stalls, b_fad, b_fbd, b_pcsrc);
    end
  endtask

  task automatic test_alu_ops();
    issue(32'h2001_0005, 32'h0);
    issue(32'h0001_2880, 32'h0);
    issue(32'h0001_302A, 32'h0);
    issue(32'h0001_3822, 32'h0);
    issue(32'h00E0_582A, 32'h0);
    issue(32'h0025_4024, 32'h0);
    issue(32'h0101_4825, 32'h0);
    issue(32'h0009_5042, 32'h0);
    issue(32'h2021_0001, 32'h0);
    issue(32'h2021_0001, 32'h0);
    issue(32'h0021_9820, 32'h0);
    checks++;
    if (fae !== 2'b10) begin
      errors++;
      $display("FAIL fwd_priority: got AE=%b, required 10", fae);
    end
  endtask

  task automatic test_store_zero();
    issue(32'h2001_0005, 32'h0);
    issue(32'hAC01_0004, 32'h0);
    issue(32'h8C0C_0004, 32'h0);
    issue(32'h018C_6820, 32'h0);
    issue(32'h2000_00FF, 32'h0);
    issue(32'h0000_7020, 32'h0);
    checks++;
    if (fae !== 2'b00 || fbe !== 2'b00) begin
      errors++;
      $display("FAIL zero_no_fwd_m: got AE=%b BE=%b, required 00 00", fae, fbe);
    end
    issue(32'h0000_7820, 32'h0);
    checks++;
    if (fae !== 2'b00 || fbe !== 2'b00) begin
      errors++;
      $display("FAIL zero_no_fwd_w: got AE=%b BE=%b, required 00 00", fae, fbe);
    end
  endtask

  task automatic test_mid_reset();
    issue(NOP_I, 32'h0);
    issue(NOP_I, 32'h0);
    issue(32'h2001_0009, 32'h0);
    issue(32'h2002_0003, 32'h0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if ({RegWriteM, MemtoRegM, MemWriteM, WriteRegM, ALUOutM, WriteDataM, StallD} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rw=%0b wr=%0d alu=%h, required all 0",
               RegWriteM, WriteRegM, ALUOutM);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    issue(32'h0022_9020, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) issue(NOP_I, 32'h0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending commits, required 0", sb.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ex_forward();
    test_load_use();
    test_branch();
    test_alu_ops();
    test_store_zero();
    test_mid_reset();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
